// File: rtl/udp_tx_frame_arbiter_pkg.sv
// udp_stream_pkg: shared UDP header layout and arbiter state encoding.
package udp_stream_pkg;
    localparam int HDR_WIDTH     = 112;
    localparam int SRC_IP_LSB    = 0;
    localparam int DEST_IP_LSB   = 32;
    localparam int SRC_PORT_LSB  = 64;
    localparam int DEST_PORT_LSB = 80;
    localparam int LENGTH_LSB    = 96;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        HDR     = 2'd1,
        PAYLOAD = 2'd2
    } state_t;
endpackage

// File: rtl/udp_tx_frame_arbiter_if.sv
// udp_tx_frame_arbiter_if: UDP header stream plus AXI-Stream payload, N lanes side by side.
interface udp_tx_frame_arbiter_if #(
    parameter int N          = 1,
    parameter int DATA_WIDTH = 64,
    parameter int KEEP_WIDTH = DATA_WIDTH / 8,
    parameter int HDR_WIDTH  = udp_stream_pkg::HDR_WIDTH
);
    logic [N-1:0]            hdr_valid;
    logic [N-1:0]            hdr_ready;
    logic [N*HDR_WIDTH-1:0]  hdr_data;
    logic [N*DATA_WIDTH-1:0] payload_tdata;
    logic [N*KEEP_WIDTH-1:0] payload_tkeep;
    logic [N-1:0]            payload_tvalid;
    logic [N-1:0]            payload_tready;
    logic [N-1:0]            payload_tlast;
    logic [N-1:0]            payload_tuser;

    modport master (
        output hdr_valid, hdr_data, payload_tdata, payload_tkeep, payload_tvalid, payload_tlast, payload_tuser,
        input  hdr_ready, payload_tready
    );
    modport slave (
        input  hdr_valid, hdr_data, payload_tdata, payload_tkeep, payload_tvalid, payload_tlast, payload_tuser,
        output hdr_ready, payload_tready
    );
endinterface

// File: rtl/udp_tx_frame_arbiter_rr_priority_select.sv
// rr_priority_select: picks the first request after ptr, wrapping, as one-hot plus index.
module rr_priority_select #(
    parameter int PORTS = 2,
    parameter int IW    = $clog2(PORTS)
) (
    input  logic [PORTS-1:0] req,
    input  logic [IW-1:0]    ptr,
    output logic [PORTS-1:0] grant,
    output logic [IW-1:0]    index,
    output logic             any
);
    assign any = |req;

    // Walk from farthest to nearest so the nearest request overwrites the rest.
    always_comb begin
        grant = '0;
        index = '0;
        for (int k = PORTS; k > 0; k--)
            if (req[(int'(ptr) + k) % PORTS]) begin
                grant = PORTS'(1) << ((int'(ptr) + k) % PORTS);
                index = IW'((int'(ptr) + k) % PORTS);
            end
    end
endmodule

// File: rtl/udp_tx_frame_arbiter.sv
// udp_tx_frame_arbiter: frame-level round-robin sharing of one UDP TX header+payload stream.
module udp_tx_frame_arbiter
    import udp_stream_pkg::*;
#(
    parameter int PORTS      = 2,
    parameter int DATA_WIDTH = 64,
    parameter int KEEP_WIDTH = DATA_WIDTH / 8,
    parameter int HDR_WIDTH  = udp_stream_pkg::HDR_WIDTH
) (
    input  logic                       clk,
    input  logic                       rst,
    udp_tx_frame_arbiter_if.slave      s,
    udp_tx_frame_arbiter_if.master     m,
    output logic [$clog2(PORTS)-1:0]   grant_index,
    output logic                       busy
);
    localparam int IW = $clog2(PORTS);

    state_t           state, state_next;
    logic [IW-1:0]    ptr, sel_index;
    logic [PORTS-1:0] sel_grant, grant_oh;
    logic             sel_any, hdr_fire, last_fire;

    rr_priority_select #(.PORTS(PORTS), .IW(IW)) u_sel (
        .req   (s.hdr_valid),
        .ptr   (ptr),
        .grant (sel_grant),
        .index (sel_index),
        .any   (sel_any)
    );

    assign hdr_fire  = m.hdr_valid[0] & m.hdr_ready[0];
    assign last_fire = m.payload_tvalid[0] & m.payload_tready[0] & m.payload_tlast[0];
    assign busy      = state != IDLE;

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            ptr         <= '0;
            grant_index <= '0;
            grant_oh    <= '0;
        end else begin
            state <= state_next;
            if (state == IDLE && sel_any) begin
                grant_index <= sel_index;
                grant_oh    <= sel_grant;
            end
            if (last_fire) ptr <= grant_index;
        end
    end

    always_comb begin
        state_next = (state == IDLE)    ? (sel_any ? HDR : IDLE) :
                     (state == HDR)     ? (hdr_fire ? PAYLOAD : HDR) :
                     (state == PAYLOAD) ? (last_fire ? IDLE : PAYLOAD) : IDLE;
    end

    // Payload is gated off until the header handshake has moved us to PAYLOAD.
    always_comb begin
        m.hdr_valid      = (state == HDR) & s.hdr_valid[grant_index];
        m.hdr_data       = (state == IDLE) ? '0 : s.hdr_data[grant_index*HDR_WIDTH +: HDR_WIDTH];
        m.payload_tvalid = (state == PAYLOAD) & s.payload_tvalid[grant_index];
        m.payload_tdata  = (state == IDLE) ? '0 : s.payload_tdata[grant_index*DATA_WIDTH +: DATA_WIDTH];
        m.payload_tkeep  = (state == IDLE) ? '0 : s.payload_tkeep[grant_index*KEEP_WIDTH +: KEEP_WIDTH];
        m.payload_tlast  = (state == IDLE) ? 1'b0 : s.payload_tlast[grant_index];
        m.payload_tuser  = (state == IDLE) ? 1'b0 : s.payload_tuser[grant_index];
        s.hdr_ready      = (state == HDR && m.hdr_ready[0]) ? grant_oh : '0;
        s.payload_tready = (state == PAYLOAD && m.payload_tready[0]) ? grant_oh : '0;
    end
endmodule
